div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 25 ++
 rtl/add32.sv | 23 ++
 rtl/div_seq.sv | 207 ++++++++++++++++++++
 tb/tb_div_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// iteration count and a few 32-bit constants used for the special cases.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    ABS_B = 3'd2,
    RUN   = 3'd3,
    FIX_Q = 3'd4,
    FIX_R = 3'd5,
    DONE  = 3'd6
  } state_t;

  // One RUN cycle per quotient bit
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Last RUN iteration index, expressed in counter width
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

endpackage

// File: rtl/add32.sv
// 32-bit adder with carry-in, carry-out and signed overflow flag.
// The only arithmetic element of the divider; every subtraction and
// negation is expressed as an addition with inverted operand and cin=1.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  logic [32:0] w_full;

  // Plain ripple-free behavioural add; synthesis picks the structure
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    sum    = w_full[31:0];
    cout   = w_full[32];
    ovf    = (a[31] == b[31]) && (w_full[31] != a[31]);
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit integer divider (DIV/DIVU/REM/REMU semantics).
// Restoring division, one quotient bit per cycle, with sign handling done
// by negating operands before and results after the iteration loop.
//
// Handshake: i_start is sampled only while the block is IDLE (o_busy low).
// A request raised while o_busy is high, including the o_valid cycle, is
// dropped. o_valid pulses for one cycle; o_quotient/o_remainder change only
// when a new result is produced and are stable while o_valid is high.
module div_seq
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output state_t          o_dbg_state
);

  state_t            r_state;
  state_t            w_state_nxt;

  // r_quo holds the dividend before RUN and shifts into the quotient
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_div;
  logic [XLEN-1:0]   r_out_q;
  logic [XLEN-1:0]   r_out_r;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_signed;
  logic              r_q_neg;
  logic              r_r_neg;

  logic [XLEN-1:0]   w_add_a;
  logic [XLEN-1:0]   w_add_b;
  logic              w_add_cin;
  logic [XLEN-1:0]   w_add_sum;
  logic              w_add_cout;
  logic              w_unused_ovf;

  logic [XLEN-1:0]   w_partial;
  logic              w_accept;
  logic              w_div_zero;
  logic              w_sovf;
  logic              w_special;

  // Partial remainder after the left shift of {rem,quo}
  assign w_partial  = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  // Carry-out means partial >= divisor; a set pre-shift rem MSB means the
  // 33-bit partial exceeds any 32-bit divisor even if the adder did not carry
  assign w_accept   = w_add_cout | r_rem[XLEN-1];

  assign w_div_zero = (r_div == '0);
  assign w_sovf     = r_signed && (r_quo == INT_MIN) && (r_div == ALL_ONES);
  assign w_special  = w_div_zero | w_sovf;

  // Operand muxing for the single shared adder, selected by state
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      ABS_A: begin
        w_add_a   = ~r_quo;
        w_add_cin = 1'b1;
      end
      ABS_B: begin
        w_add_a   = ~r_div;
        w_add_cin = 1'b1;
      end
      RUN: begin
        w_add_a   = w_partial;
        w_add_b   = ~r_div;
        w_add_cin = 1'b1;
      end
      FIX_Q: begin
        w_add_a   = ~r_quo;
        w_add_cin = 1'b1;
      end
      FIX_R: begin
        w_add_a   = ~r_rem;
        w_add_cin = 1'b1;
      end
      default: begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
      end
    endcase
  end

  add32 u_add32 (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_add_sum),
    .cout (w_add_cout),
    .ovf  (w_unused_ovf)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = ABS_A;
      ABS_A:   w_state_nxt = w_special ? DONE : ABS_B;
      ABS_B:   w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST_ITER) w_state_nxt = FIX_Q;
      FIX_Q:   w_state_nxt = FIX_R;
      FIX_R:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Iteration counter: cleared on accept, wraps back to 0 after the last RUN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Working registers: operand latch, absolute values, iteration, sign fix
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_signed <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_quo    <= i_dividend;
            r_div    <= i_divisor;
            r_rem    <= '0;
            r_signed <= i_signed;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
          end
        end
        ABS_A: begin
          if (r_signed && r_quo[XLEN-1]) r_quo <= w_add_sum;
          r_q_neg <= r_signed & (r_quo[XLEN-1] ^ r_div[XLEN-1]);
          r_r_neg <= r_signed & r_quo[XLEN-1];
        end
        ABS_B: begin
          if (r_signed && r_div[XLEN-1]) r_div <= w_add_sum;
        end
        RUN: begin
          r_rem <= w_accept ? w_add_sum : w_partial;
          r_quo <= {r_quo[XLEN-2:0], w_accept};
        end
        FIX_Q: begin
          if (r_q_neg) r_quo <= w_add_sum;
        end
        FIX_R: begin
          if (r_r_neg) r_rem <= w_add_sum;
        end
        default: begin
          r_quo <= r_quo;
        end
      endcase
    end
  end

  // Result registers: loaded on the edge into DONE so they are valid with o_valid
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_q <= '0;
      r_out_r <= '0;
    end else if (r_state == ABS_A && w_special) begin
      // r_quo still holds the untouched dividend here
      r_out_q <= w_div_zero ? ALL_ONES : INT_MIN;
      r_out_r <= w_div_zero ? r_quo : '0;
    end else if (r_state == FIX_R) begin
      r_out_q <= r_quo;
      r_out_r <= r_r_neg ? w_add_sum : r_rem;
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_valid     = (r_state == DONE);
  assign o_quotient  = r_out_q;
  assign o_remainder = r_out_r;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed corner cases, randomized operations checked
// against an arithmetic reference model, start-ignore and mid-run reset.
module tb_div_seq;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  state_t      o_dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  div_seq #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RISC-V DIV/DIVU/REM/REMU results and expected latency
  function automatic void ref_div(input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output int lat);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 2;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      lat = 37;
    end else begin
      q = a / b; r = a % b; lat = 37;
    end
  endfunction

  // Driver: issue one request from IDLE and wait for o_valid.
  // lat = cycle index after the accept edge in which o_valid was seen (-1 on timeout).
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    int c;
    @(negedge clk);
    i_start = 1'b1; i_signed = sgn; i_dividend = a; i_divisor = b;
    @(negedge clk);
    i_start = 1'b0;
    lat = -1; q = 32'd0; r = 32'd0;
    c = 1;
    while (lat < 0 && c <= 60) begin
      if (c > 1) @(negedge clk);
      if (o_valid === 1'b1) begin
        lat = c; q = o_quotient; r = o_remainder;
      end
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_quotient !== 32'd0) $display("FAIL reset_quo got %h want 0", o_quotient); else pass_cnt++;
    total_cnt++; if (o_remainder !== 32'd0) $display("FAIL reset_rem got %h want 0", o_remainder); else pass_cnt++;
    total_cnt++; if (o_dbg_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", o_dbg_state); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] q, r, eq, er;
    int lat, elat;
    logic        sg [7];
    logic [31:0] av [7];
    logic [31:0] bv [7];
    sg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    av = '{32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    bv = '{32'd7, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    for (int i = 0; i < 7; i++) begin
      run_op(sg[i], av[i], bv[i], q, r, lat);
      ref_div(sg[i], av[i], bv[i], eq, er, elat);
      total_cnt++; if (q !== eq) $display("FAIL dir%0d_quo got %h want %h", i, q, eq); else pass_cnt++;
      total_cnt++; if (r !== er) $display("FAIL dir%0d_rem got %h want %h", i, r, er); else pass_cnt++;
      total_cnt++; if (lat !== elat) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); else pass_cnt++;
      if (i == 0) begin
        @(negedge clk);
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL dir0_busy_after got %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL dir0_valid_pulse got %b want 0", o_valid); else pass_cnt++;
      end
    end
    // Spot-check the literal values the reference must agree with
    run_op(1'b0, 32'd100, 32'd7, q, r, lat);
    total_cnt++; if (q !== 32'd14 || r !== 32'd2) $display("FAIL lit_100_7 got %0d r %0d want 14 r 2", q, r); else pass_cnt++;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, lat);
    total_cnt++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) $display("FAIL lit_m7_2 got %h r %h want fffffffd r ffffffff", q, r); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic sgn;
    int lat, elat;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2, 3: b = 32'($urandom_range(1, 20));
        4: b = -32'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      run_op(sgn, a, b, q, r, lat);
      ref_div(sgn, a, b, eq, er, elat);
      total_cnt++; if (q !== eq) $display("FAIL rnd%0d_quo s=%b %h/%h got %h want %h", i, sgn, a, b, q, eq); else pass_cnt++;
      total_cnt++; if (r !== er) $display("FAIL rnd%0d_rem s=%b %h/%h got %h want %h", i, sgn, a, b, r, er); else pass_cnt++;
      total_cnt++; if (lat !== elat) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, elat); else pass_cnt++;
    end
  endtask

  // Start pulses while busy (mid-RUN and in the o_valid cycle) must be dropped
  task automatic test_start_ignored();
    int lat, c;
    logic [31:0] q, r;
    @(negedge clk);
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
    @(negedge clk);
    i_start = 1'b0;
    lat = -1; q = '0; r = '0; c = 1;
    while (lat < 0 && c <= 60) begin
      if (c > 1) @(negedge clk);
      // Cycle 12 is RUN iteration 10 (cycles 1,2 are ABS_A, ABS_B)
      if (c == 12) begin
        i_start = 1'b1; i_signed = 1'b1; i_dividend = 32'h5555; i_divisor = 32'd3;
      end else begin
        i_start = 1'b0;
      end
      if (o_valid === 1'b1) begin
        lat = c; q = o_quotient; r = o_remainder;
      end
      c++;
    end
    total_cnt++; if (q !== 32'd14 || r !== 32'd2) $display("FAIL ign_run_result got %0d r %0d want 14 r 2", q, r); else pass_cnt++;
    total_cnt++; if (lat !== 37) $display("FAIL ign_run_latency got %0d want 37", lat); else pass_cnt++;
    // Request raised in the o_valid cycle
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd50; i_divisor = 32'd5;
    @(negedge clk);
    i_start = 1'b0;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL ign_valid_busy got %b want 0", o_busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (o_busy !== 1'b0 || o_valid !== 1'b0) $display("FAIL ign_valid_idle busy %b valid %b want 0 0", o_busy, o_valid); else pass_cnt++;
    // Results are held while idle
    total_cnt++; if (o_quotient !== 32'd14 || o_remainder !== 32'd2) $display("FAIL hold_result got %0d r %0d want 14 r 2", o_quotient, o_remainder); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [31:0] q, r;
    int lat;
    @(negedge clk);
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (21) @(negedge clk);   // now in cycle 22 = RUN iteration 20
    rst_n = 1'b0;
    #1;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_quotient !== 32'd0 || o_remainder !== 32'd0) $display("FAIL rst_mid_out got %h r %h want 0 r 0", o_quotient, o_remainder); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1 || o_busy === 1'b1) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rst_mid_no_valid got %0d active cycles want 0", seen); else pass_cnt++;
    run_op(1'b0, 32'd100, 32'd7, q, r, lat);
    total_cnt++; if (q !== 32'd14 || r !== 32'd2) $display("FAIL rst_after_result got %0d r %0d want 14 r 2", q, r); else pass_cnt++;
    total_cnt++; if (lat !== 37) $display("FAIL rst_after_latency got %0d want 37", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
